seq_accumulator: RTL

//  Parametrised successor to the count-down accumulator. On a start pulse, latches count N and mode,

---
 rtl/seq_acc_pkg.sv | 14 +
 rtl/acc_addsub.sv | 25 ++
 rtl/seq_accumulator.sv | 102 ++++++++++
 3 files changed

// File: rtl/seq_acc_pkg.sv
// Shared types and constants for the sequential accumulator.
// State encoding and add/subtract mode selectors.
package seq_acc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/acc_addsub.sv
// K-bit adder/subtractor; o_cb is carry-out when adding, borrow when subtracting.
module acc_addsub #(
   parameter int unsigned K = 8
) (
   input  logic [K-1:0] i_a,
   input  logic [K-1:0] i_b,
   input  logic         i_sub,
   output logic [K-1:0] o_sum,
   output logic         o_cb
);
   import seq_acc_pkg::*;

   logic [K:0] w_wide;

   // The extra top bit is the carry on add and wraps to 1 on borrow when subtracting.
   always_comb begin
      w_wide = '0;
      if (i_sub == MODE_SUB) w_wide = {1'b0, i_a} - {1'b0, i_b};
      else                   w_wide = {1'b0, i_a} + {1'b0, i_b};
   end

   assign o_sum = w_wide[K-1:0];
   assign o_cb  = w_wide[K];

endmodule

// File: rtl/seq_accumulator.sv
// Start/busy/done accumulator: adds or subtracts X into Result for N cycles.
// Optional clamping on carry/borrow via macro SEQ_ACC_SATURATE_EN.
module seq_accumulator #(
   parameter int unsigned K = 8,
   parameter int unsigned M = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [M-1:0] N,
   input  logic         sub,
   input  logic [K-1:0] X,
   output logic [K-1:0] Result,
   output logic         busy,
   output logic         done,
   output logic         ovf
);
   import seq_acc_pkg::*;

   localparam logic [M-1:0] CNT_ONE = {{(M-1){1'b0}}, 1'b1};

   state_t       r_state;
   state_t       w_next_state;
   logic [M-1:0] r_cnt;
   logic         r_mode;
   logic [K-1:0] r_result;
   logic         r_ovf;
   logic [K-1:0] w_sum;
   logic         w_cb;
   logic [K-1:0] w_next_result;

   acc_addsub #(.K(K)) u_addsub (
      .i_a   (r_result),
      .i_b   (X),
      .i_sub (r_mode),
      .o_sum (w_sum),
      .o_cb  (w_cb)
   );

`ifdef SEQ_ACC_SATURATE_EN
   assign w_next_result = w_cb ? ((r_mode == MODE_SUB) ? '0 : '1) : w_sum;
`else
   assign w_next_result = w_sum;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next_state = (N == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (r_cnt == CNT_ONE) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Operands latch only on an accepted start, so N/sub/start are ignored while busy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_mode   <= MODE_ADD;
         r_result <= '0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cnt    <= N;
                  r_mode   <= sub;
                  r_result <= '0;
                  r_ovf    <= 1'b0;
               end
            end
            ST_RUN: begin
               r_result <= w_next_result;
               r_cnt    <= r_cnt - CNT_ONE;
               r_ovf    <= r_ovf | w_cb;
            end
            default: ;
         endcase
      end
   end

   assign Result = r_result;
   assign ovf    = r_ovf;

endmodule
